operand_fetch: RTL and testbench

//   Decode/operand stage directly upstream of the ALU in the RV32I core. Holds the 32x32

---
 rtl/operand_fetch_if.sv | 52 +++++
 rtl/operand_fetch.sv | 274 +++++++++++++++++++++++++++
 tb/tb_operand_fetch.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// -----------------------------------------------------------------------------
// operand_fetch_if
//   Bundles the instruction-in handshake, the writeback port, the flush line and
//   the operand-out handshake of the operand fetch stage.
//
//   Signals
//     in_valid / in_ready     instruction offer / stage acceptance
//     in_instr, in_pc         RV32I instruction word and its PC
//     wb_en, wb_rd, wb_data   register-file writeback from the end of the pipe
//     flush                   drop held and offered instructions
//     out_valid / out_ready   operand slot full / ALU consumes slot
//     reg_a, reg_rdx          ALU operands A and B
//     out_rd, out_pc          destination register and PC of held instruction
//     out_illegal             held instruction has an unsupported opcode
//
//   Modports
//     master  the surrounding pipeline (fetch, writeback and ALU side)
//     slave   the operand fetch stage itself
// -----------------------------------------------------------------------------
interface operand_fetch_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_instr;
   logic [XLEN-1:0] in_pc;
   logic            wb_en;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] reg_a;
   logic [XLEN-1:0] reg_rdx;
   logic [4:0]      out_rd;
   logic [XLEN-1:0] out_pc;
   logic            out_illegal;

   modport master (
      output in_valid, in_instr, in_pc,
      output wb_en, wb_rd, wb_data,
      output flush, out_ready,
      input  in_ready, out_valid, reg_a, reg_rdx, out_rd, out_pc, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc,
      input  wb_en, wb_rd, wb_data,
      input  flush, out_ready,
      output in_ready, out_valid, reg_a, reg_rdx, out_rd, out_pc, out_illegal
   );
endinterface

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//   Decode/operand stage in front of the ALU of the RV32I core. Holds the
//   32x32 integer register file (x0 reads as zero), decodes rs1/rs2/immediate
//   from the incoming instruction and registers ALU operands behind a single
//   valid/ready slot. Writeback is bypassed into same-cycle reads, and a held
//   (stalled) instruction has its register operands refreshed by writeback.
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-high; clears slot, outputs and x1..x31
//     bus    operand_fetch_if.slave: instruction in, writeback, flush,
//            operand out (see operand_fetch_if for the signal list)
// -----------------------------------------------------------------------------
module operand_fetch #(
   parameter int XLEN     = 32,
   parameter int RF_DEPTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   operand_fetch_if.slave bus
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic {
      SLOT_EMPTY,
      SLOT_FULL
   } slot_t;

   typedef enum logic [1:0] {
      A_ZERO,
      A_RS1,
      A_PC
   } asel_t;

   typedef enum logic [1:0] {
      B_ZERO,
      B_RS2,
      B_IMM
   } bsel_t;

   slot_t state_q, state_d;

   // register file; entry 0 exists but is never read (x0 muxed to zero)
   logic [XLEN-1:0] rf [RF_DEPTH];

   // decode
   logic [6:0]      opcode;
   logic [4:0]      rs1, rs2, rd_field;
   logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_j;
   asel_t           dec_a_sel;
   bsel_t           dec_b_sel;
   logic [XLEN-1:0] dec_imm;
   logic            dec_rd_en;
   logic            dec_illegal;

   // read ports and operand mux
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic [XLEN-1:0] op_a, op_b;

   // handshake / control
   logic            slot_full;
   logic            in_ready_c;
   logic            accept;
   logic            consume;
   logic            wb_hit;
   logic            refresh_a, refresh_b;

   // held state
   logic [XLEN-1:0] reg_a_q, reg_rdx_q, pc_q;
   logic [4:0]      rd_q;
   logic            illegal_q;
   logic [4:0]      h_rs1, h_rs2;
   logic            h_a_reg, h_b_reg;

   // ---------------------------------------------------------------------------
   // Field extraction
   // ---------------------------------------------------------------------------
   assign opcode   = bus.in_instr[6:0];
   assign rd_field = bus.in_instr[11:7];
   assign rs1      = bus.in_instr[19:15];
   assign rs2      = bus.in_instr[24:20];

   assign imm_i = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
   assign imm_s = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
   assign imm_u = {bus.in_instr[31:12], 12'b0};
   assign imm_j = {{(XLEN-21){bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                   bus.in_instr[20], bus.in_instr[30:21], 1'b0};

   // ---------------------------------------------------------------------------
   // Opcode decode: operand sources, immediate and destination enable
   // ---------------------------------------------------------------------------
   always_comb begin
      dec_a_sel   = A_ZERO;
      dec_b_sel   = B_ZERO;
      dec_imm     = '0;
      dec_rd_en   = 1'b0;
      dec_illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec_a_sel = A_RS1;
            dec_b_sel = B_RS2;
            dec_rd_en = 1'b1;
         end
         OPC_BRANCH: begin
            dec_a_sel = A_RS1;
            dec_b_sel = B_RS2;
         end
         OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
            dec_a_sel = A_RS1;
            dec_b_sel = B_IMM;
            dec_imm   = imm_i;
            dec_rd_en = 1'b1;
         end
         OPC_STORE: begin
            dec_a_sel = A_RS1;
            dec_b_sel = B_IMM;
            dec_imm   = imm_s;
         end
         OPC_LUI: begin
            dec_b_sel = B_IMM;
            dec_imm   = imm_u;
            dec_rd_en = 1'b1;
         end
         OPC_AUIPC: begin
            dec_a_sel = A_PC;
            dec_b_sel = B_IMM;
            dec_imm   = imm_u;
            dec_rd_en = 1'b1;
         end
         OPC_JAL: begin
            dec_a_sel = A_PC;
            dec_b_sel = B_IMM;
            dec_imm   = imm_j;
            dec_rd_en = 1'b1;
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Register read with same-cycle writeback bypass
   // ---------------------------------------------------------------------------
   assign wb_hit = bus.wb_en && (bus.wb_rd != '0);

   always_comb begin
      rs1_val = rf[rs1];
      rs2_val = rf[rs2];
      if (rs1 == '0) begin
         rs1_val = '0;
      end else if (wb_hit && (bus.wb_rd == rs1)) begin
         rs1_val = bus.wb_data;
      end
      if (rs2 == '0) begin
         rs2_val = '0;
      end else if (wb_hit && (bus.wb_rd == rs2)) begin
         rs2_val = bus.wb_data;
      end
   end

   always_comb begin
      op_a = '0;
      op_b = '0;
      case (dec_a_sel)
         A_RS1:   op_a = rs1_val;
         A_PC:    op_a = bus.in_pc;
         default: op_a = '0;
      endcase
      case (dec_b_sel)
         B_RS2:   op_b = rs2_val;
         B_IMM:   op_b = dec_imm;
         default: op_b = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Slot control: state register plus next-state / handshake logic
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SLOT_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      slot_full  = (state_q == SLOT_FULL);
      in_ready_c = !slot_full || bus.out_ready;
      accept     = bus.in_valid && in_ready_c && !bus.flush;
      consume    = slot_full && bus.out_ready;
      // refresh only a stalled slot whose operand came from the matching register
      refresh_a  = slot_full && !bus.out_ready && !bus.flush && wb_hit &&
                   h_a_reg && (bus.wb_rd == h_rs1);
      refresh_b  = slot_full && !bus.out_ready && !bus.flush && wb_hit &&
                   h_b_reg && (bus.wb_rd == h_rs2);
      state_d    = state_q;
      if (bus.flush) begin
         state_d = SLOT_EMPTY;
      end else if (accept) begin
         state_d = SLOT_FULL;
      end else if (consume) begin
         state_d = SLOT_EMPTY;
      end
   end

   // ---------------------------------------------------------------------------
   // Held operands and instruction attributes
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         reg_a_q   <= '0;
         reg_rdx_q <= '0;
         pc_q      <= '0;
         rd_q      <= '0;
         illegal_q <= 1'b0;
         h_rs1     <= '0;
         h_rs2     <= '0;
         h_a_reg   <= 1'b0;
         h_b_reg   <= 1'b0;
      end else if (accept) begin
         reg_a_q   <= op_a;
         reg_rdx_q <= op_b;
         pc_q      <= bus.in_pc;
         rd_q      <= dec_rd_en ? rd_field : 5'd0;
         illegal_q <= dec_illegal;
         h_rs1     <= rs1;
         h_rs2     <= rs2;
         h_a_reg   <= (dec_a_sel == A_RS1);
         h_b_reg   <= (dec_b_sel == B_RS2);
      end else begin
         if (refresh_a) begin
            reg_a_q <= bus.wb_data;
         end
         if (refresh_b) begin
            reg_rdx_q <= bus.wb_data;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Register file: writes ignored to x0 and during reset
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         rf <= '{default: '0};
      end else if (wb_hit) begin
         rf[bus.wb_rd] <= bus.wb_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid   = slot_full;
   assign bus.reg_a       = reg_a_q;
   assign bus.reg_rdx     = reg_rdx_q;
   assign bus.out_pc      = pc_q;
   assign bus.out_rd      = rd_q;
   assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
//   Self-checking bench for operand_fetch. Accepted instructions push their
//   expected operands onto a scoreboard queue; consumed slots pop and compare.
//   Decode coverage comes from a vector table; stall refresh, flush and reset
//   while stalled are exercised by short hand-written sequences.
// -----------------------------------------------------------------------------
module tb_operand_fetch;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        ill;
   } vec_t;

   logic clk;
   logic reset;

   operand_fetch_if #(.XLEN(32)) bus ();

   operand_fetch #(.XLEN(32), .RF_DEPTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   int   accepted = 0;
   int   consumed = 0;
   vec_t sb[$];
   vec_t drv_exp;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // encoders
   function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, opc};
   endfunction

   function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [11:0] imm);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_u(input logic [6:0] opc, input logic [4:0] rd,
                                         input logic [19:0] imm);
      return {imm, rd, opc};
   endfunction

   function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [4:0] low);
      return {7'b0, rs2, rs1, 3'b000, low, 7'b1100011};
   endfunction

   function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic ill);
      vec_t v;
      v.instr = instr;
      v.pc    = pc;
      v.a     = a;
      v.b     = b;
      v.rd    = rd;
      v.ill   = ill;
      return v;
   endfunction

   // scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      vec_t e;
      logic exp_rdy;
      if (reset) begin
         sb.delete();
      end else begin
         exp_rdy = (sb.size() == 0) || bus.out_ready;
         chk("out_valid", {31'b0, bus.out_valid}, {31'b0, sb.size() != 0});
         chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
         if (bus.flush) begin
            if (sb.size() != 0) begin
               void'(sb.pop_front());
            end
         end else begin
            if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
               e = sb.pop_front();
               consumed++;
               chk("reg_a", bus.reg_a, e.a);
               chk("reg_rdx", bus.reg_rdx, e.b);
               chk("out_rd", {27'b0, bus.out_rd}, {27'b0, e.rd});
               chk("out_pc", bus.out_pc, e.pc);
               chk("out_illegal", {31'b0, bus.out_illegal}, {31'b0, e.ill});
            end
            if (bus.in_valid && exp_rdy) begin
               sb.push_back(drv_exp);
               accepted++;
            end
         end
      end
   end

   task automatic send(input vec_t v, input bit toggle);
      int n0;
      int w;
      n0 = accepted;
      w  = 0;
      bus.in_valid = 1'b1;
      bus.in_instr = v.instr;
      bus.in_pc    = v.pc;
      drv_exp      = v;
      while (accepted == n0 && w < 20) begin
         if (toggle) bus.out_ready = ~bus.out_ready;
         tick();
         w++;
      end
      if (accepted == n0) chk("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      bus.out_ready = 1'b1;
      while (sb.size() != 0 && w < 10) begin
         tick();
         w++;
      end
      chk("drain", sb.size(), 32'd0);
   endtask

   task automatic wb(input logic [4:0] rd, input logic [31:0] data);
      bus.wb_en   = 1'b1;
      bus.wb_rd   = rd;
      bus.wb_data = data;
   endtask

   initial begin
      vec_t tbl[10];
      vec_t t;
      int   c0;

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.in_pc     = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      drv_exp       = mk(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
      wb(5'd3, 32'hBAD0BAD0);           // must be ignored during reset
      tick();
      tick();
      reset     = 1'b0;
      bus.wb_en = 1'b0;

      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      chk("rst_reg_a", bus.reg_a, 32'd0);
      chk("rst_reg_rdx", bus.reg_rdx, 32'd0);
      chk("rst_out_pc", bus.out_pc, 32'd0);
      chk("rst_out_rd", {27'b0, bus.out_rd}, 32'd0);
      chk("rst_out_illegal", {31'b0, bus.out_illegal}, 32'd0);

      // every register reads zero after reset
      bus.out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         send(mk(enc_r(5'd1, 5'(2*k), 5'(2*k+1)), 32'(4*k), 32'h0, 32'h0, 5'd1, 1'b0), 1'b0);
      end
      drain();

      // x0 is hardwired: writes ignored, including same-cycle bypass
      wb(5'd0, 32'hDEAD);
      tick();
      send(mk(enc_r(5'd0, 5'd0, 5'd0), 32'h80, 32'h0, 32'h0, 5'd0, 1'b0), 1'b0);
      bus.wb_en = 1'b0;
      drain();

      // same-cycle writeback bypass: addi x6,x5,-1 with wb x5=0x1234
      wb(5'd5, 32'h1234);
      send(mk(enc_i(7'b0010011, 5'd6, 5'd5, 12'hFFF), 32'h90, 32'h1234, 32'hFFFFFFFF,
              5'd6, 1'b0), 1'b0);
      bus.wb_en = 1'b0;
      drain();

      // decode table (x5 = 0x1234, others zero)
      tbl[0] = mk(enc_u(7'b0110111, 5'd7, 20'h12345), 32'h100, 32'h0, 32'h12345000, 5'd7, 1'b0);
      tbl[1] = mk(enc_u(7'b0010111, 5'd8, 20'hFFFFF), 32'h104, 32'h104, 32'hFFFFF000, 5'd8, 1'b0);
      tbl[2] = mk(enc_s(5'd5, 5'd0, 12'hFFC), 32'h108, 32'h1234, 32'hFFFFFFFC, 5'd0, 1'b0);
      tbl[3] = mk(32'hFFFFFFFF, 32'h10C, 32'h0, 32'h0, 5'd0, 1'b1);
      tbl[4] = mk(enc_j(5'd1, 21'h100802), 32'h110, 32'h110, 32'hFFF00802, 5'd1, 1'b0);
      tbl[5] = mk(enc_b(5'd5, 5'd5, 5'b10101), 32'h114, 32'h1234, 32'h1234, 5'd0, 1'b0);
      tbl[6] = mk(enc_i(7'b0000011, 5'd9, 5'd5, 12'h7FF), 32'h118, 32'h1234, 32'h7FF, 5'd9, 1'b0);
      tbl[7] = mk(enc_i(7'b1100111, 5'd10, 5'd5, 12'h800), 32'h11C, 32'h1234, 32'hFFFFF800,
                  5'd10, 1'b0);
      tbl[8] = mk(enc_r(5'd11, 5'd5, 5'd0), 32'h120, 32'h1234, 32'h0, 5'd11, 1'b0);
      tbl[9] = mk(enc_i(7'b0010011, 5'd12, 5'd5, 12'h123), 32'h124, 32'h1234, 32'h123,
                  5'd12, 1'b0);

      // back-to-back, one accept per cycle
      c0 = accepted;
      for (int i = 0; i < 10; i++) send(tbl[i], 1'b0);
      chk("b2b_accepts", 32'(accepted - c0), 32'd10);
      drain();

      // same vectors with out_ready toggling
      c0 = consumed;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) send(tbl[i], 1'b1);
      drain();
      chk("toggle_consumed", 32'(consumed - c0), 32'd10);

      // stall refresh: add x1,x2,x3 with x2=7, x3=0x33
      wb(5'd2, 32'd7);
      tick();
      wb(5'd3, 32'h33);
      tick();
      bus.wb_en     = 1'b0;
      bus.out_ready = 1'b0;
      send(mk(enc_r(5'd1, 5'd2, 5'd3), 32'h200, 32'd7, 32'h33, 5'd1, 1'b0), 1'b0);
      chk("stall_a_init", bus.reg_a, 32'd7);
      wb(5'd2, 32'd9);
      t = sb[0]; t.a = 32'd9; sb[0] = t;
      tick();
      chk("refresh_a", bus.reg_a, 32'd9);
      chk("refresh_valid", {31'b0, bus.out_valid}, 32'd1);
      wb(5'd3, 32'h44);
      t = sb[0]; t.b = 32'h44; sb[0] = t;
      tick();
      chk("refresh_b", bus.reg_rdx, 32'h44);
      bus.wb_en     = 1'b0;
      c0            = consumed;
      bus.out_ready = 1'b1;
      tick();
      chk("consume_once", 32'(consumed - c0), 32'd1);
      tick();
      chk("consume_no_dup", 32'(consumed - c0), 32'd1);

      // immediate operand never refreshed; consume beats matching writeback
      bus.out_ready = 1'b0;
      send(mk(enc_i(7'b0010011, 5'd4, 5'd2, 12'h005), 32'h204, 32'd9, 32'd5, 5'd4, 1'b0), 1'b0);
      wb(5'd5, 32'hAAAA);
      tick();
      chk("imm_no_refresh", bus.reg_rdx, 32'd5);
      wb(5'd2, 32'h77);
      bus.out_ready = 1'b1;
      tick();
      bus.wb_en = 1'b0;
      chk("consume_no_refresh", bus.reg_a, 32'd9);
      drain();

      // flush with held and offered instruction, concurrent writeback
      bus.out_ready = 1'b0;
      send(mk(enc_r(5'd1, 5'd2, 5'd3), 32'h300, 32'h77, 32'h44, 5'd1, 1'b0), 1'b0);
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_instr = enc_u(7'b0110111, 5'd12, 20'hABCDE);
      bus.in_pc    = 32'h304;
      wb(5'd13, 32'h5555);
      tick();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      bus.wb_en    = 1'b0;
      chk("flush_valid", {31'b0, bus.out_valid}, 32'd0);
      bus.out_ready = 1'b1;
      send(mk(enc_r(5'd1, 5'd13, 5'd0), 32'h308, 32'h5555, 32'h0, 5'd1, 1'b0), 1'b0);
      drain();

      // reset while stalled
      bus.out_ready = 1'b0;
      send(mk(enc_r(5'd1, 5'd5, 5'd13), 32'h400, 32'hAAAA, 32'h5555, 5'd1, 1'b0), 1'b0);
      chk("pre_reset_valid", {31'b0, bus.out_valid}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst2_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst2_reg_a", bus.reg_a, 32'd0);
      chk("rst2_pc", bus.out_pc, 32'd0);
      bus.out_ready = 1'b1;
      send(mk(enc_r(5'd1, 5'd5, 5'd13), 32'h404, 32'h0, 32'h0, 5'd1, 1'b0), 1'b0);
      send(mk(enc_r(5'd1, 5'd2, 5'd3), 32'h408, 32'h0, 32'h0, 5'd1, 1'b0), 1'b0);
      drain();
      tick();
      chk("end_idle", {31'b0, bus.out_valid}, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
